// File: rtl/issq_pkg.sv
// Shared issue-queue types: default sizes, the queue entry record and the
// ROB-relative depth helper used by the flush logic.
package issq_pkg;

   localparam int DEPTH = 8;
   localparam int PHY_W = 6;
   localparam int ROB_W = 5;

   typedef struct packed {
      logic             valid;
      logic             rs_rdy;
      logic             rt_rdy;
      logic [PHY_W-1:0] rs_tag;
      logic [PHY_W-1:0] rt_tag;
      logic [PHY_W-1:0] rd_tag;
      logic [ROB_W-1:0] rob_tag;
      logic [2:0]       opcode;
      logic [15:0]      imm;
   } issq_entry_t;

   // Distance of a ROB tag from the ROB head, wrapping modulo 2^ROB_W.
   function automatic logic [ROB_W-1:0] rob_depth(input logic [ROB_W-1:0] tag,
                                                  input logic [ROB_W-1:0] top);
      return tag - top;
   endfunction

endpackage

// File: rtl/int_issq_select.sv
// Fixed-priority picker: lowest-index set bit of ready wins. Produces a
// one-hot grant, its binary index and an any-ready flag.
module int_issq_select #(
   parameter int N     = 8,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     ready,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = |ready;
      for (int i = N - 1; i >= 0; i--) begin
         if (ready[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/int_issue_queue.sv
// Collapsing integer issue queue with CDB wakeup and ROB-depth flush.
// Define INT_ISSQ_CDB_BYPASS_EN to let a live CDB tag count as ready for selection.
module int_issue_queue
   import issq_pkg::issq_entry_t;
   import issq_pkg::rob_depth;
#(
   parameter int DEPTH = 8,
   parameter int PHY_W = 6,
   parameter int ROB_W = 5
) (
   input  logic             Clk,
   input  logic             Resetb,
   input  logic             Dis_IntIssquenable,
   input  logic             Dis_RsDataRdy,
   input  logic             Dis_RtDataRdy,
   input  logic [PHY_W-1:0] Dis_RsPhyAddr,
   input  logic [PHY_W-1:0] Dis_RtPhyAddr,
   input  logic [PHY_W-1:0] Dis_RdPhyAddr,
   input  logic [ROB_W-1:0] Dis_RobTag,
   input  logic [2:0]       Dis_Opcode,
   input  logic [15:0]      Dis_Imm,
   input  logic             Cdb_Valid,
   input  logic [PHY_W-1:0] Cdb_RdPhyAddr,
   input  logic             Cdb_Flush,
   input  logic [ROB_W-1:0] Cdb_RobDepth,
   input  logic [ROB_W-1:0] Rob_TopPtr,
   input  logic             Iss_Int,
   output logic             IssInt_Rdy,
   output logic             IntIss_Full,
   output logic [PHY_W-1:0] Iss_RsPhyAddr,
   output logic [PHY_W-1:0] Iss_RtPhyAddr,
   output logic [PHY_W-1:0] Iss_RdPhyAddr,
   output logic [ROB_W-1:0] Iss_RobTag,
   output logic [2:0]       Iss_Opcode,
   output logic [15:0]      Iss_Imm
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // Entry storage uses the package widths; DEPTH/PHY_W/ROB_W must match issq_pkg.
   issq_entry_t      q     [DEPTH];
   issq_entry_t      q_nxt [DEPTH];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [DEPTH-1:0] byp_rs, byp_rt, ready, grant;
   logic [IDX_W-1:0] sel_idx;
   logic             any_rdy;
   logic             issue;

   always_comb begin
      byp_rs = '0;
      byp_rt = '0;
`ifdef INT_ISSQ_CDB_BYPASS_EN
      for (int i = 0; i < DEPTH; i++) begin
         byp_rs[i] = Cdb_Valid && (q[i].rs_tag == Cdb_RdPhyAddr);
         byp_rt[i] = Cdb_Valid && (q[i].rt_tag == Cdb_RdPhyAddr);
      end
`endif
      for (int i = 0; i < DEPTH; i++)
         ready[i] = q[i].valid && (q[i].rs_rdy || byp_rs[i]) && (q[i].rt_rdy || byp_rt[i]);
   end

   int_issq_select #(.N(DEPTH), .IDX_W(IDX_W)) u_select (
      .ready (ready),
      .grant (grant),
      .idx   (sel_idx),
      .any   (any_rdy)
   );

   // Issue handshake: IssInt_Rdy offers the oldest ready entry on Iss_*; Iss_Int
   // in the same cycle accepts it and the entry leaves at the next edge.
   // Iss_Int while IssInt_Rdy is low is ignored.
   assign IssInt_Rdy  = any_rdy;
   assign issue       = Iss_Int && any_rdy;
   assign IntIss_Full = (count == CNT_W'(DEPTH));

   always_comb begin
      Iss_RsPhyAddr = '0;
      Iss_RtPhyAddr = '0;
      Iss_RdPhyAddr = '0;
      Iss_RobTag    = '0;
      Iss_Opcode    = '0;
      Iss_Imm       = '0;
      if (any_rdy) begin
         Iss_RsPhyAddr = q[sel_idx].rs_tag;
         Iss_RtPhyAddr = q[sel_idx].rt_tag;
         Iss_RdPhyAddr = q[sel_idx].rd_tag;
         Iss_RobTag    = q[sel_idx].rob_tag;
         Iss_Opcode    = q[sel_idx].opcode;
         Iss_Imm       = q[sel_idx].imm;
      end
   end

   // Wake, drop issued/flushed entries, compact in order, then append dispatch.
   always_comb begin
      issq_entry_t      e;
      logic             keep;
      logic [CNT_W-1:0] wr;
      e    = '0;
      keep = 1'b0;
      wr   = '0;
      for (int i = 0; i < DEPTH; i++) q_nxt[i] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         e = q[i];
         if (Cdb_Valid && (e.rs_tag == Cdb_RdPhyAddr)) e.rs_rdy = 1'b1;
         if (Cdb_Valid && (e.rt_tag == Cdb_RdPhyAddr)) e.rt_rdy = 1'b1;
         keep = e.valid && !(issue && grant[i]) &&
                !(Cdb_Flush && (rob_depth(e.rob_tag, Rob_TopPtr) > Cdb_RobDepth));
         if (keep) begin
            q_nxt[wr[IDX_W-1:0]] = e;
            wr = wr + CNT_W'(1);
         end
      end
      if (Dis_IntIssquenable && !Cdb_Flush && (wr < CNT_W'(DEPTH))) begin
         e         = '0;
         e.valid   = 1'b1;
         e.rs_rdy  = Dis_RsDataRdy || (Cdb_Valid && (Dis_RsPhyAddr == Cdb_RdPhyAddr));
         e.rt_rdy  = Dis_RtDataRdy || (Cdb_Valid && (Dis_RtPhyAddr == Cdb_RdPhyAddr));
         e.rs_tag  = Dis_RsPhyAddr;
         e.rt_tag  = Dis_RtPhyAddr;
         e.rd_tag  = Dis_RdPhyAddr;
         e.rob_tag = Dis_RobTag;
         e.opcode  = Dis_Opcode;
         e.imm     = Dis_Imm;
         q_nxt[wr[IDX_W-1:0]] = e;
         wr = wr + CNT_W'(1);
      end
      count_nxt = wr;
   end

   always_ff @(posedge Clk or negedge Resetb) begin
      if (!Resetb) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
         count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed scenarios then random traffic, all
// checked against an in-order list model of the queue contents.
module tb_int_issue_queue;

   logic        Clk = 1'b0;
   logic        Resetb;
   logic        Dis_IntIssquenable, Dis_RsDataRdy, Dis_RtDataRdy;
   logic [5:0]  Dis_RsPhyAddr, Dis_RtPhyAddr, Dis_RdPhyAddr;
   logic [4:0]  Dis_RobTag;
   logic [2:0]  Dis_Opcode;
   logic [15:0] Dis_Imm;
   logic        Cdb_Valid;
   logic [5:0]  Cdb_RdPhyAddr;
   logic        Cdb_Flush;
   logic [4:0]  Cdb_RobDepth, Rob_TopPtr;
   logic        Iss_Int;
   logic        IssInt_Rdy, IntIss_Full;
   logic [5:0]  Iss_RsPhyAddr, Iss_RtPhyAddr, Iss_RdPhyAddr;
   logic [4:0]  Iss_RobTag;
   logic [2:0]  Iss_Opcode;
   logic [15:0] Iss_Imm;

   int_issue_queue dut (
      .Clk(Clk), .Resetb(Resetb),
      .Dis_IntIssquenable(Dis_IntIssquenable), .Dis_RsDataRdy(Dis_RsDataRdy),
      .Dis_RtDataRdy(Dis_RtDataRdy), .Dis_RsPhyAddr(Dis_RsPhyAddr),
      .Dis_RtPhyAddr(Dis_RtPhyAddr), .Dis_RdPhyAddr(Dis_RdPhyAddr),
      .Dis_RobTag(Dis_RobTag), .Dis_Opcode(Dis_Opcode), .Dis_Imm(Dis_Imm),
      .Cdb_Valid(Cdb_Valid), .Cdb_RdPhyAddr(Cdb_RdPhyAddr), .Cdb_Flush(Cdb_Flush),
      .Cdb_RobDepth(Cdb_RobDepth), .Rob_TopPtr(Rob_TopPtr), .Iss_Int(Iss_Int),
      .IssInt_Rdy(IssInt_Rdy), .IntIss_Full(IntIss_Full),
      .Iss_RsPhyAddr(Iss_RsPhyAddr), .Iss_RtPhyAddr(Iss_RtPhyAddr),
      .Iss_RdPhyAddr(Iss_RdPhyAddr), .Iss_RobTag(Iss_RobTag),
      .Iss_Opcode(Iss_Opcode), .Iss_Imm(Iss_Imm)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [5:0]  rs, rt, rd;
      logic [4:0]  rob;
      logic [2:0]  op;
      logic [15:0] imm;
      bit          rs_rdy, rt_rdy;
   } m_t;

   m_t exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready(m_t e);
      bit rs = e.rs_rdy;
      bit rt = e.rt_rdy;
`ifdef INT_ISSQ_CDB_BYPASS_EN
      if (Cdb_Valid && e.rs == Cdb_RdPhyAddr) rs = 1'b1;
      if (Cdb_Valid && e.rt == Cdb_RdPhyAddr) rt = 1'b1;
`endif
      return rs && rt;
   endfunction

   function automatic int sel_of();
      int s = -1;
      foreach (exp_q[i]) if (s < 0 && m_ready(exp_q[i])) s = i;
      return s;
   endfunction

   task automatic check_all();
      int s;
      #1;
      s = sel_of();
      chk("rdy", IssInt_Rdy, s >= 0);
      chk("full", IntIss_Full, exp_q.size() == 8);
      chk("count", dut.count, exp_q.size());
      if (s >= 0) begin
         chk("iss_rs", Iss_RsPhyAddr, exp_q[s].rs);
         chk("iss_rt", Iss_RtPhyAddr, exp_q[s].rt);
         chk("iss_rd", Iss_RdPhyAddr, exp_q[s].rd);
         chk("iss_rob", Iss_RobTag, exp_q[s].rob);
         chk("iss_op", Iss_Opcode, exp_q[s].op);
         chk("iss_imm", Iss_Imm, exp_q[s].imm);
      end else begin
         chk("idle_fields", {Iss_RsPhyAddr, Iss_RtPhyAddr, Iss_RdPhyAddr, Iss_RobTag, Iss_Opcode}, 0);
         chk("idle_imm", Iss_Imm, 0);
      end
   endtask

   task automatic tick();
      m_t nq[$];
      m_t e;
      int s = sel_of();
      bit issue = Iss_Int && (s >= 0);
      foreach (exp_q[i]) begin
         e = exp_q[i];
         if (issue && i == s) continue;
         if (Cdb_Flush && 5'(e.rob - Rob_TopPtr) > Cdb_RobDepth) continue;
         if (Cdb_Valid && e.rs == Cdb_RdPhyAddr) e.rs_rdy = 1'b1;
         if (Cdb_Valid && e.rt == Cdb_RdPhyAddr) e.rt_rdy = 1'b1;
         nq.push_back(e);
      end
      if (Dis_IntIssquenable && !Cdb_Flush && nq.size() < 8) begin
         e.rs = Dis_RsPhyAddr; e.rt = Dis_RtPhyAddr; e.rd = Dis_RdPhyAddr;
         e.rob = Dis_RobTag; e.op = Dis_Opcode; e.imm = Dis_Imm;
         e.rs_rdy = Dis_RsDataRdy || (Cdb_Valid && Dis_RsPhyAddr == Cdb_RdPhyAddr);
         e.rt_rdy = Dis_RtDataRdy || (Cdb_Valid && Dis_RtPhyAddr == Cdb_RdPhyAddr);
         nq.push_back(e);
      end
      @(posedge Clk);
      exp_q = nq;
      #1;
   endtask

   task automatic idle();
      Dis_IntIssquenable = 0; Cdb_Valid = 0; Cdb_Flush = 0; Iss_Int = 0;
   endtask

   task automatic set_dis(input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                          input bit rsr, input bit rtr, input logic [4:0] rob,
                          input logic [15:0] imm);
      Dis_IntIssquenable = 1; Dis_RsPhyAddr = rs; Dis_RtPhyAddr = rt; Dis_RdPhyAddr = rd;
      Dis_RsDataRdy = rsr; Dis_RtDataRdy = rtr; Dis_RobTag = rob;
      Dis_Imm = imm; Dis_Opcode = imm[2:0];
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"}, IssInt_Rdy, 0);
      chk({tag, "_full"}, IntIss_Full, 0);
      chk({tag, "_tags"}, {Iss_RsPhyAddr, Iss_RtPhyAddr, Iss_RdPhyAddr, Iss_RobTag, Iss_Opcode}, 0);
      chk({tag, "_imm"}, Iss_Imm, 0);
   endtask

   task automatic do_reset();
      Resetb = 0;
      #1;
      chk_zero("rst");
      exp_q.delete();
      idle();
      @(posedge Clk);
      #1;
      Resetb = 1;
   endtask

   initial begin
      #300000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      Resetb = 0;
      idle();
      set_dis(0, 0, 0, 0, 0, 0, 0);
      Dis_IntIssquenable = 0;
      Cdb_RdPhyAddr = 0; Cdb_RobDepth = 0; Rob_TopPtr = 0;
      repeat (3) @(posedge Clk);
      #1;
      chk_zero("reset");
      check_all();
      Resetb = 1;

      // Both operands ready at dispatch: visible next cycle, gone after grant.
      set_dis(1, 2, 3, 1, 1, 3, 16'h0011);
      check_all(); chk("t1_pre", IssInt_Rdy, 0);
      tick(); idle();
      check_all(); chk("t1_rdy", IssInt_Rdy, 1); chk("t1_rob", Iss_RobTag, 3);
      Iss_Int = 1;
      check_all(); tick(); idle();
      check_all(); chk("t1_gone", IssInt_Rdy, 0);

      // CDB wakeup of rs=12.
      set_dis(12, 13, 14, 0, 1, 4, 16'h0022);
      check_all(); tick(); idle();
      Cdb_Valid = 1; Cdb_RdPhyAddr = 12;
      check_all();
`ifdef INT_ISSQ_CDB_BYPASS_EN
      chk("t2_byp", IssInt_Rdy, 1);
`else
      chk("t2_nobyp", IssInt_Rdy, 0);
`endif
      tick(); idle();
      check_all(); chk("t2_rdy", IssInt_Rdy, 1); chk("t2_rs", Iss_RsPhyAddr, 12);
      Iss_Int = 1;
      check_all(); tick(); idle();

      // Fill with nothing ready, wake and issue entry 5.
      for (int i = 0; i < 8; i++) begin
         set_dis(6'(20 + i), 40, 6'(50 + i), 0, 1, 5'(8 + i), 16'(i));
         check_all(); tick();
      end
      idle();
      check_all(); chk("t3_full", IntIss_Full, 1);
      Cdb_Valid = 1; Cdb_RdPhyAddr = 25;
      check_all(); tick(); idle();
      check_all(); chk("t3_sel", Iss_Imm, 5);
      Iss_Int = 1;
      check_all(); tick(); idle();
      check_all(); chk("t3_notfull", IntIss_Full, 0);
      chk("t3_q5", dut.q[5].imm, 6); chk("t3_q6", dut.q[6].imm, 7);

      // Full queue with simultaneous issue and dispatch.
      set_dis(30, 40, 60, 0, 1, 20, 16'h0077);
      check_all(); tick(); idle();
      check_all(); chk("t5_full", IntIss_Full, 1);
      Cdb_Valid = 1; Cdb_RdPhyAddr = 26;
      check_all(); tick(); idle();
      Iss_Int = 1;
      set_dis(31, 40, 61, 0, 1, 21, 16'h0099);
      check_all(); chk("t5_sel", Iss_Imm, 6);
      tick(); idle();
      check_all(); chk("t5_count", dut.count, 8); chk("t5_q7", dut.q[7].imm, 16'h0099);
      chk("t5_full2", IntIss_Full, 1);

      // Flush by ROB depth with a same-cycle dispatch that must be dropped.
      do_reset();
      check_all();
      Rob_TopPtr = 0;
      for (int i = 0; i < 4; i++) begin
         set_dis(6'(33 + i), 40, 6'(44 + i), 0, 1, (i == 0) ? 5'd1 : 5'(2 * i), 16'(16'h100 + i));
         check_all(); tick();
      end
      idle();
      Cdb_Flush = 1; Cdb_RobDepth = 2;
      set_dis(37, 40, 48, 1, 1, 7, 16'h0107);
      check_all(); tick(); idle();
      check_all(); chk("t4_count", dut.count, 2);
      chk("t4_q0", dut.q[0].rob_tag, 1); chk("t4_q1", dut.q[1].rob_tag, 2);

      // Reset mid-stream with four entries.
      set_dis(1, 2, 3, 1, 1, 3, 16'h0203); check_all(); tick();
      set_dis(4, 5, 6, 1, 1, 5, 16'h0205); check_all(); tick(); idle();
      check_all(); chk("t6_rdy", IssInt_Rdy, 1); chk("t6_count", dut.count, 4);
      #2;
      do_reset();
      check_all(); chk("t6_empty", dut.count, 0);

      // Random traffic.
      Rob_TopPtr = 5'($urandom_range(0, 31));
      for (int n = 0; n < 1500; n++) begin
         Dis_IntIssquenable = ($urandom_range(0, 99) < ((exp_q.size() == 8) ? 20 : 55));
         Dis_RsPhyAddr = 6'($urandom_range(0, 15));
         Dis_RtPhyAddr = 6'($urandom_range(0, 15));
         Dis_RdPhyAddr = 6'($urandom_range(0, 63));
         Dis_RsDataRdy = ($urandom_range(0, 99) < 40);
         Dis_RtDataRdy = ($urandom_range(0, 99) < 40);
         Dis_RobTag    = 5'($urandom_range(0, 31));
         Dis_Opcode    = 3'($urandom_range(0, 7));
         Dis_Imm       = 16'($urandom);
         Cdb_Valid     = ($urandom_range(0, 99) < 40);
         Cdb_RdPhyAddr = 6'($urandom_range(0, 15));
         Cdb_Flush     = ($urandom_range(0, 99) < 3);
         Cdb_RobDepth  = 5'($urandom_range(0, 31));
         Iss_Int       = ($urandom_range(0, 99) < 55);
         if ($urandom_range(0, 99) < 5) Rob_TopPtr = 5'($urandom_range(0, 31));
         check_all();
         tick();
      end
      idle();
      check_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
